// File: rtl/bram_asym_init_if.sv
// Bus bundle for bram_asym_init: narrow write port and wide read port.
interface bram_asym_init_if #(
  parameter int WRITE_WIDTH      = 32,
  parameter int READ_WIDTH       = 64,
  parameter int WRITE_ADDR_WIDTH = 10,
  parameter int READ_ADDR_WIDTH  = 9
);
  logic                        w_valid;
  logic [WRITE_ADDR_WIDTH-1:0] w_addr;
  logic [WRITE_WIDTH-1:0]      w_data;
  logic                        r_valid;
  logic [READ_ADDR_WIDTH-1:0]  r_addr;
  logic [READ_WIDTH-1:0]       r_data;
  logic                        r_data_valid;

  modport master (
    output w_valid, w_addr, w_data, r_valid, r_addr,
    input  r_data, r_data_valid
  );

  modport slave (
    input  w_valid, w_addr, w_data, r_valid, r_addr,
    output r_data, r_data_valid
  );
endinterface

// File: rtl/bram_asym_init.sv
// Width-asymmetric simple-dual-port RAM with a row-per-cycle zero-fill engine,
// read-valid pipeline, optional output register and selectable collision mode.
module bram_asym_init #(
  parameter int WRITE_WIDTH      = 32,
  parameter int READ_WIDTH       = 64,
  parameter int WRITE_ADDR_WIDTH = 10,
  parameter int READ_ADDR_WIDTH  = 9,
  parameter int OUT_REG          = 0,
  parameter int READ_MODE        = 0,
  parameter int CLEAR_ON_RESET   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  output logic              init_done,
  bram_asym_init_if.slave   bus
);
  localparam int unsigned RATIO = READ_WIDTH / WRITE_WIDTH;
  localparam int unsigned LR    = $clog2(RATIO);
  localparam int unsigned LW    = (LR > 0) ? LR : 1;
  localparam int unsigned ROWS  = 2 ** READ_ADDR_WIDTH;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                     state_q, state_d;
  logic [READ_ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [READ_WIDTH-1:0]      mem [ROWS];

  logic [READ_ADDR_WIDTH-1:0] w_row;
  logic [LW-1:0]              w_lane;
  int unsigned                lane_base;
  logic                       w_acc, r_acc;
  logic [READ_WIDTH-1:0]      rd_row;
  logic [READ_WIDTH-1:0]      rd_q;
  logic                       rd_v;

  generate
    if (LR > 0) begin : g_lanes
      assign w_row  = bus.w_addr[WRITE_ADDR_WIDTH-1:LR];
      assign w_lane = bus.w_addr[LR-1:0];
    end else begin : g_sym
      assign w_row  = bus.w_addr;
      assign w_lane = '0;
    end
  endgenerate

  always_comb lane_base = 32'(w_lane) * WRITE_WIDTH;

  assign init_done = (state_q == IDLE);
  assign w_acc     = bus.w_valid & init_done;
  assign r_acc     = bus.r_valid & init_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Writes are gated by init_done, so the clear engine never competes with them.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR)
      mem[clr_cnt_q] <= '0;
    else if (w_acc)
      mem[w_row][lane_base +: WRITE_WIDTH] <= bus.w_data;
  end

  // Write-forward overlays only the written lane onto the pre-write row.
  always_comb begin
    rd_row = mem[bus.r_addr];
    if ((READ_MODE == 1) && w_acc && (w_row == bus.r_addr))
      rd_row[lane_base +: WRITE_WIDTH] = bus.w_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q <= '0;
      rd_v <= 1'b0;
    end else begin
      rd_v <= r_acc;
      if (r_acc) rd_q <= rd_row;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [READ_WIDTH-1:0] out_q;
      logic                  out_v;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          out_q <= '0;
          out_v <= 1'b0;
        end else begin
          out_v <= rd_v;
          if (rd_v) out_q <= rd_q;
        end
      end
      assign bus.r_data       = out_q;
      assign bus.r_data_valid = out_v;
    end else begin : g_noreg
      assign bus.r_data       = rd_q;
      assign bus.r_data_valid = rd_v;
    end
  endgenerate
endmodule
